// File: rtl/bp_hard_decision_pkg.sv
// Shared BP decoder definitions: control state encoding and the default
// code geometry used by the processing-element array and its consumers.
package bp_hard_decision_pkg;

   localparam int BP_BIT_N    = 8;
   localparam int BP_N        = 8;
   localparam int BP_MAX_ITER = 40;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } bp_state_e;

endpackage

// File: rtl/bp_hard_decision.sv
// Hard-decision slicer and iteration controller: slices decision LLRs to bits,
// tracks decision stability and halts the BP loop on convergence or MAX_ITER.
module bp_hard_decision
   import bp_hard_decision_pkg::*;
#(
   parameter int BIT_N       = BP_BIT_N,
   parameter int N           = BP_N,
   parameter int MAX_ITER    = BP_MAX_ITER,
   parameter int STABLE_ITER = 3,
   parameter int ITER_W      = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 llr_valid,
   input  logic [N*BIT_N-1:0]   llr_in,
   output logic                 busy,
   output logic                 halt,
   output logic                 dec_valid,
   output logic [N-1:0]         dec_bits,
   output logic                 early_stop,
   output logic [ITER_W-1:0]    iter_cnt
);

   bp_state_e           state_q, state_d;
   logic [ITER_W-1:0]   iter_q, iter_d;
   logic [ITER_W-1:0]   stable_q, stable_d;
   logic                first_q, first_d;
   logic [N-1:0]        prev_q, prev_d;
   logic [N-1:0]        dec_bits_q, dec_bits_d;
   logic                early_q, early_d;
   logic                dec_valid_q, dec_valid_d;
   logic                busy_q, busy_d;
   logic                halt_q, halt_d;

   logic [N-1:0]        hard;
   logic [ITER_W-1:0]   iter_inc;
   logic [ITER_W-1:0]   stable_nxt;

   // Sign bit is the hard decision; zero slices to 0, most-negative to 1.
   for (genvar i = 0; i < N; i++) begin : g_slice
      assign hard[i] = llr_in[i*BIT_N + BIT_N - 1];
   end

   always_comb begin
      iter_inc   = iter_q + ITER_W'(1);
      stable_nxt = '0;
      if (!first_q && (hard == prev_q)) begin
         stable_nxt = stable_q + ITER_W'(1);
      end
   end

   always_comb begin
      state_d     = state_q;
      iter_d      = iter_q;
      stable_d    = stable_q;
      first_d     = first_q;
      prev_d      = prev_q;
      dec_bits_d  = dec_bits_q;
      early_d     = early_q;
      dec_valid_d = 1'b0;

      // start has priority over any sample in the same cycle, in every state.
      if (start) begin
         state_d    = ST_RUN;
         iter_d     = '0;
         stable_d   = '0;
         first_d    = 1'b1;
         dec_bits_d = '0;
         early_d    = 1'b0;
      end else if ((state_q == ST_RUN) && llr_valid) begin
         iter_d     = iter_inc;
         stable_d   = stable_nxt;
         first_d    = 1'b0;
         prev_d     = hard;
         dec_bits_d = hard;
         if (stable_nxt == ITER_W'(STABLE_ITER)) begin
            state_d     = ST_DONE;
            early_d     = 1'b1;
            dec_valid_d = 1'b1;
         end else if (iter_inc == ITER_W'(MAX_ITER)) begin
            state_d     = ST_DONE;
            early_d     = 1'b0;
            dec_valid_d = 1'b1;
         end
      end

      busy_d = (state_d == ST_RUN);
      halt_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         iter_q      <= '0;
         stable_q    <= '0;
         first_q     <= 1'b1;
         prev_q      <= '0;
         dec_bits_q  <= '0;
         early_q     <= 1'b0;
         dec_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         halt_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         iter_q      <= iter_d;
         stable_q    <= stable_d;
         first_q     <= first_d;
         prev_q      <= prev_d;
         dec_bits_q  <= dec_bits_d;
         early_q     <= early_d;
         dec_valid_q <= dec_valid_d;
         busy_q      <= busy_d;
         halt_q      <= halt_d;
      end
   end

   assign busy       = busy_q;
   assign halt       = halt_q;
   assign dec_valid  = dec_valid_q;
   assign dec_bits   = dec_bits_q;
   assign early_stop = early_q;
   assign iter_cnt   = iter_q;

endmodule

// File: tb/tb_bp_hard_decision.sv
// Self-checking bench for bp_hard_decision: directed scenarios plus random
// frames compared against a run-length model of the termination rules.
module tb_bp_hard_decision;

   localparam int BIT_N       = 8;
   localparam int N           = 8;
   localparam int MAX_ITER    = 40;
   localparam int STABLE_ITER = 3;
   localparam int ITER_W      = 6;

   logic                clk = 1'b0;
   logic                rst;
   logic                start;
   logic                llr_valid;
   logic [N*BIT_N-1:0]  llr_in;
   logic                busy;
   logic                halt;
   logic                dec_valid;
   logic [N-1:0]        dec_bits;
   logic                early_stop;
   logic [ITER_W-1:0]   iter_cnt;

   int errors = 0;
   int checks = 0;

   logic [N-1:0] pats [0:63];

   bp_hard_decision #(
      .BIT_N(BIT_N), .N(N), .MAX_ITER(MAX_ITER),
      .STABLE_ITER(STABLE_ITER), .ITER_W(ITER_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .llr_valid(llr_valid),
      .llr_in(llr_in), .busy(busy), .halt(halt), .dec_valid(dec_valid),
      .dec_bits(dec_bits), .early_stop(early_stop), .iter_cnt(iter_cnt)
   );

   always #5 clk = ~clk;

   // Random-magnitude LLR vector whose signs spell out the given bit pattern.
   function automatic logic [N*BIT_N-1:0] mk_llr(input logic [N-1:0] p);
      logic [N*BIT_N-1:0] v;
      logic [BIT_N-1:0]   e;
      v = '0;
      for (int i = 0; i < N; i++) begin
         e = BIT_N'($urandom_range(0, 127));
         e[BIT_N-1] = p[i];
         v[i*BIT_N +: BIT_N] = e;
      end
      return v;
   endfunction

   // Frame terminates at the first iteration closing a run of STABLE_ITER+1
   // identical decisions, else at MAX_ITER.
   function automatic int model_stop(output bit conv);
      bit same;
      conv = 1'b0;
      for (int k = 0; k < MAX_ITER; k++) begin
         same = (k >= STABLE_ITER);
         for (int j = 1; j <= STABLE_ITER && same; j++)
            if (pats[k-j] !== pats[k]) same = 1'b0;
         if (same) begin
            conv = 1'b1;
            return k + 1;
         end
      end
      return MAX_ITER;
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [N*BIT_N-1:0] v);
      llr_in    = v;
      llr_valid = 1'b1;
      tick();
      llr_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; llr_valid = 1'b0; llr_in = '0;
      tick(); tick();
      checks++;
      if ({busy, halt, dec_valid, dec_bits, early_stop, iter_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_init: got busy=%b halt=%b dv=%b bits=%h es=%b it=%0d want all 0",
                  busy, halt, dec_valid, dec_bits, early_stop, iter_cnt);
      end
      rst = 1'b0;
      tick();
      pulse_start();
      send(mk_llr(8'h3C));
      send(mk_llr(8'h3C));
      checks++;
      if (iter_cnt !== 6'd2 || busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_pre: got it=%0d busy=%b want 2 1", iter_cnt, busy);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, halt, dec_valid, dec_bits, early_stop, iter_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_async: got busy=%b halt=%b bits=%h it=%0d want all 0",
                  busy, halt, dec_bits, iter_cnt);
      end
      tick();
      rst = 1'b0;
      send(mk_llr(8'h3C));
      tick();
      checks++;
      if (iter_cnt !== '0 || busy !== 1'b0 || dec_bits !== '0 || dec_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle_ignore: got it=%0d busy=%b bits=%h dv=%b want 0 0 00 0",
                  iter_cnt, busy, dec_bits, dec_valid);
      end
   endtask

   task automatic test_early_stop();
      pulse_start();
      for (int k = 0; k < 4; k++) begin
         send(mk_llr(8'hA5));
         if (k < 3) begin
            checks++;
            if (dec_valid !== 1'b0 || busy !== 1'b1) begin
               errors++;
               $display("FAIL early_mid%0d: got dv=%b busy=%b want 0 1", k, dec_valid, busy);
            end
         end
      end
      checks++;
      if (dec_valid !== 1'b1 || dec_bits !== 8'hA5 || early_stop !== 1'b1 ||
          iter_cnt !== 6'd4 || halt !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL early_done: got dv=%b bits=%h es=%b it=%0d halt=%b busy=%b want 1 a5 1 4 1 0",
                  dec_valid, dec_bits, early_stop, iter_cnt, halt, busy);
      end
      tick();
      checks++;
      if (dec_valid !== 1'b0 || halt !== 1'b1) begin
         errors++;
         $display("FAIL early_dv_pulse: got dv=%b halt=%b want 0 1", dec_valid, halt);
      end
   endtask

   task automatic test_stability();
      logic [N-1:0] seq [6];
      seq = '{8'hA5, 8'hA5, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
      pulse_start();
      checks++;
      if (halt !== 1'b0 || busy !== 1'b1 || iter_cnt !== '0 || dec_bits !== '0) begin
         errors++;
         $display("FAIL restart_from_done: got halt=%b busy=%b it=%0d bits=%h want 0 1 0 00",
                  halt, busy, iter_cnt, dec_bits);
      end
      for (int k = 0; k < 6; k++) begin
         send(mk_llr(seq[k]));
         checks++;
         if (dec_valid !== (k == 5)) begin
            errors++;
            $display("FAIL stab_dv%0d: got %b want %b", k, dec_valid, (k == 5));
         end
      end
      checks++;
      if (iter_cnt !== 6'd6 || dec_bits !== 8'h5A || early_stop !== 1'b1) begin
         errors++;
         $display("FAIL stab_done: got it=%0d bits=%h es=%b want 6 5a 1",
                  iter_cnt, dec_bits, early_stop);
      end
   endtask

   task automatic test_max_iter();
      pulse_start();
      for (int k = 0; k < MAX_ITER; k++) begin
         send(mk_llr((k % 2 == 0) ? 8'h0F : 8'hF0));
         if (k == MAX_ITER - 2) begin
            checks++;
            if (dec_valid !== 1'b0 || busy !== 1'b1 || iter_cnt !== 6'd39) begin
               errors++;
               $display("FAIL max_39: got dv=%b busy=%b it=%0d want 0 1 39", dec_valid, busy, iter_cnt);
            end
         end
      end
      checks++;
      if (dec_valid !== 1'b1 || early_stop !== 1'b0 || iter_cnt !== 6'd40 ||
          dec_bits !== 8'hF0 || halt !== 1'b1) begin
         errors++;
         $display("FAIL max_done: got dv=%b es=%b it=%0d bits=%h halt=%b want 1 0 40 f0 1",
                  dec_valid, early_stop, iter_cnt, dec_bits, halt);
      end
      send(mk_llr(8'h33));
      checks++;
      if (dec_valid !== 1'b0 || iter_cnt !== 6'd40 || dec_bits !== 8'hF0 || halt !== 1'b1) begin
         errors++;
         $display("FAIL max_done_ignore: got dv=%b it=%0d bits=%h halt=%b want 0 40 f0 1",
                  dec_valid, iter_cnt, dec_bits, halt);
      end
   endtask

   task automatic test_slicer();
      logic [N*BIT_N-1:0] vec [3];
      logic [N-1:0]       exp [3];
      vec = '{{N{8'h00}}, {N{8'h80}}, {(N/2){8'hFF, 8'h7F}}};
      exp = '{8'h00, 8'hFF, 8'hAA};
      for (int t = 0; t < 3; t++) begin
         pulse_start();
         for (int k = 0; k < 4; k++) send(vec[t]);
         checks++;
         if (dec_valid !== 1'b1 || dec_bits !== exp[t] || early_stop !== 1'b1) begin
            errors++;
            $display("FAIL slicer%0d: got dv=%b bits=%h es=%b want 1 %h 1",
                     t, dec_valid, dec_bits, early_stop, exp[t]);
         end
      end
   endtask

   task automatic test_abort();
      pulse_start();
      for (int k = 0; k < 3; k++) send(mk_llr(8'hC3));
      start = 1'b1; llr_valid = 1'b1; llr_in = mk_llr(8'hC3);
      tick();
      start = 1'b0; llr_valid = 1'b0;
      checks++;
      if (iter_cnt !== '0 || dec_valid !== 1'b0 || busy !== 1'b1 || dec_bits !== '0) begin
         errors++;
         $display("FAIL abort: got it=%0d dv=%b busy=%b bits=%h want 0 0 1 00",
                  iter_cnt, dec_valid, busy, dec_bits);
      end
      for (int k = 0; k < 4; k++) begin
         send(mk_llr(8'hC3));
         checks++;
         if (dec_valid !== (k == 3) || iter_cnt !== 6'(k + 1)) begin
            errors++;
            $display("FAIL abort_rerun%0d: got dv=%b it=%0d want %b %0d",
                     k, dec_valid, iter_cnt, (k == 3), k + 1);
         end
      end
   endtask

   task automatic test_random_frames();
      logic [N-1:0] p0, p1;
      int  stop;
      bit  conv;
      for (int f = 0; f < 10; f++) begin
         p0 = N'($urandom); p1 = N'($urandom);
         for (int k = 0; k < MAX_ITER; k++)
            pats[k] = ($urandom_range(0, f % 3 + 1) == 0) ? p1 : p0;
         if (f == 9)
            for (int k = 0; k < MAX_ITER; k++) pats[k] = (k % 3 == 0) ? ~p0 : p0;
         stop = model_stop(conv);
         pulse_start();
         for (int k = 0; k < stop; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            send(mk_llr(pats[k]));
            checks++;
            if (dec_valid !== (k == stop - 1) || iter_cnt !== 6'(k + 1)) begin
               errors++;
               $display("FAIL rand%0d_it%0d: got dv=%b it=%0d want %b %0d",
                        f, k, dec_valid, iter_cnt, (k == stop - 1), k + 1);
            end
         end
         checks++;
         if (dec_bits !== pats[stop-1] || early_stop !== conv || halt !== 1'b1) begin
            errors++;
            $display("FAIL rand%0d_done: got bits=%h es=%b halt=%b want %h %b 1",
                     f, dec_bits, early_stop, halt, pats[stop-1], conv);
         end
      end
   endtask

   initial begin
      test_reset();
      test_early_stop();
      test_stability();
      test_max_iter();
      test_slicer();
      test_abort();
      test_random_frames();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bp_hard_decision.md
Name: bp_hard_decision

Overview:
- Downstream consumer of the BP decoder's min-sum processing-element array.
- Takes the per-iteration vector of N decision LLRs (two's complement, BIT_N bits each) and slices them to hard bits.
- Tracks iterations and decision stability. Asserts halt to stop the iteration loop on early convergence or at the iteration limit, then presents the final codeword.

Parameters:
- BIT_N, 8: width of each LLR, two's complement.
- N, 8: code length (number of LLRs per iteration).
- MAX_ITER, 40: iteration limit; forces termination.
- STABLE_ITER, 3: consecutive unchanged-decision iterations that trigger early stop.
- ITER_W, 6: width of the iteration counter; must satisfy 2^ITER_W > MAX_ITER.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle pulse; begins a new frame (also aborts a running frame).
- llr_valid  input  1  one-cycle pulse per completed decoder iteration.
- llr_in  input  N*BIT_N  decision LLRs; LLR i = llr_in[i*BIT_N +: BIT_N].
- busy  output  1  high in RUN.
- halt  output  1  high in DONE; tells the decoder to stop iterating.
- dec_valid  output  1  one-cycle pulse when dec_bits becomes final.
- dec_bits  output  N  hard decisions; bit i is taken from LLR i.
- early_stop  output  1  termination cause: 1 = convergence, 0 = MAX_ITER reached.
- iter_cnt  output  ITER_W  iterations consumed in the current or last frame.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - state = IDLE.
  - busy, halt, dec_valid, dec_bits, early_stop, iter_cnt all = 0.
  - Internal prev_bits = 0, stable_cnt = 0, first flag = 1.
- Slicer:
  - hard[i] = MSB of LLR i.
  - Zero maps to 0; the most negative value (e.g. 0x80) maps to 1.
  - No arithmetic on magnitudes.
- States: IDLE, RUN, DONE.
- IDLE:
  - llr_valid is ignored.
  - start -> RUN. Clears iter_cnt, stable_cnt, early_stop, dec_bits; sets first = 1.
- RUN, on each sampled llr_valid:
  - iter_cnt += 1; prev_bits <= hard; dec_bits <= hard; first <= 0.
  - stable_cnt update:
    - first = 1 -> stable_cnt = 0.
    - hard == prev_bits -> stable_cnt + 1.
    - otherwise -> stable_cnt = 0.
  - Termination is evaluated on the updated values within the same edge:
    - new stable_cnt == STABLE_ITER -> terminate, early_stop = 1.
    - else new iter_cnt == MAX_ITER -> terminate, early_stop = 0.
    - If both hold, early_stop = 1 (convergence has priority).
  - On terminate:
    - Same edge moves to DONE, so halt = 1 and busy = 0 from that edge.
    - dec_valid is high for exactly the one cycle after that edge.
    - Latency from the final llr_valid sample to dec_valid is 1 clock.
  - With the defaults, four identical iterations stop the frame at iter_cnt = 4.
- DONE:
  - llr_valid is ignored.
  - dec_bits, early_stop and iter_cnt hold.
  - start -> RUN with the same clearing as IDLE; halt drops on that edge.
- start in RUN:
  - Aborts and restarts with the IDLE clearing.
  - No dec_valid is produced.
- start and llr_valid in the same cycle: start wins and the sample is discarded, in every state.
- iter_cnt never exceeds MAX_ITER.
- No outputs are combinational from inputs; all are registered.

Decomposition:
- Shared BP package holds:
  - the state encoding enum (IDLE/RUN/DONE);
  - the default BIT_N, N and MAX_ITER constants shared with the processing-element array.
- Single module; no sub-module is warranted. The slicer is a one-line generate loop.

Test Plan:
- Reset: assert rst mid-RUN after 2 iterations -> all outputs 0 and state IDLE immediately. A later llr_valid without start has no effect.
- Early stop: start, then 4 iterations whose sign pattern gives 8'hA5 -> dec_valid one cycle after the 4th sample. Expect dec_bits = 8'hA5, early_stop = 1, iter_cnt = 4, halt = 1.
- Stability reset: patterns A5, A5, 5A, 5A, 5A, 5A -> stop after the 6th sample. Expect iter_cnt = 6, dec_bits = 8'h5A, early_stop = 1.
- Max iterations: 40 iterations alternating 8'h0F / 8'hF0 -> dec_valid after the 40th. Expect early_stop = 0, iter_cnt = 40, dec_bits = 8'hF0. A 41st llr_valid in DONE is ignored.
- Slicer edges: all LLRs 0x00 -> bit 0; all 0x80 -> bit 1; mixed 0x7F/0xFF alternating -> dec_bits = 8'hAA.
- Abort: after 3 identical iterations, pulse start together with llr_valid -> sample discarded, iter_cnt = 0, no dec_valid. A fresh 4 identical iterations are then needed to stop.
